// File: rtl/ternary_acc_pkg.sv
// Shared types and default widths for the ternary frame accumulator.
package ternary_acc_pkg;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_CNT_WIDTH = 16;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/ternary_adder.sv
// Three-operand unsigned adder; the only arithmetic element of the accumulator.
module ternary_adder #(
  parameter int W = 26
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum
);

  assign sum = a + b + c;

endmodule

// File: rtl/ternary_accumulator.sv
// Streaming frame accumulator: sums in_a + in_b per beat and reports the
// frame total, beat count and sticky overflow when the last beat arrives.
module ternary_accumulator
  import ternary_acc_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ACC_WIDTH = WIDTH + 8,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_ovf
);

  localparam int AW = ACC_WIDTH + 2;

  acc_state_t state_q, state_d;

  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 ovf;

  logic [AW-1:0]        add_acc, add_a, add_b, add_sum;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                 ovf_next;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 inc_carry;
  logic                 beat;

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign beat      = in_valid && in_ready && !clr;

  assign add_acc = {2'b00, acc};
  assign add_a   = {{(AW-WIDTH){1'b0}}, in_a};
  assign add_b   = {{(AW-WIDTH){1'b0}}, in_b};

  ternary_adder #(.W(AW)) u_adder (
    .a   (add_acc),
    .b   (add_a),
    .c   (add_b),
    .sum (add_sum)
  );

  assign acc_next = add_sum[ACC_WIDTH-1:0];
  assign ovf_next = ovf | (|add_sum[AW-1:ACC_WIDTH]);

  // Saturating increment built from a carry ripple so the adder above stays
  // the block's only arithmetic; an all-ones count starts with no carry in.
  always_comb begin
    cnt_next  = cnt;
    inc_carry = ~&cnt;
    for (int i = 0; i < CNT_WIDTH; i++) begin
      cnt_next[i] = cnt[i] ^ inc_carry;
      inc_carry   = inc_carry & cnt[i];
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ACCUM;
    end else begin
      unique case (state_q)
        ACCUM: if (beat && in_last) state_d = DONE;
        DONE:  if (out_ready)       state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (beat) begin
      if (in_last) begin
        out_sum   <= acc_next;
        out_count <= cnt_next;
        out_ovf   <= ovf_next;
        acc       <= '0;
        cnt       <= '0;
        ovf       <= 1'b0;
      end else begin
        acc <= acc_next;
        cnt <= cnt_next;
        ovf <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_ternary_accumulator.sv
// Self-checking bench for ternary_accumulator with an arithmetic frame model.
module tb_ternary_accumulator;

  localparam int W  = 16;
  localparam int AW = 24;
  localparam int CW = 16;
  localparam int RW = 1 + AW + CW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] out_sum;
  logic [CW-1:0] out_count;
  logic          out_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state for the frame in progress.
  longint m_total;
  int     m_beats;

  ternary_accumulator dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] observed();
    return {out_valid, out_sum, out_count, out_ovf};
  endfunction

  function automatic logic [RW-1:0] model_result();
    logic [AW-1:0] s;
    logic [CW-1:0] c;
    logic          o;
    s = AW'(m_total % (64'd1 << AW));
    c = (m_beats > 65535) ? CW'(65535) : CW'(m_beats);
    o = (m_total >= (64'd1 << AW));
    return {1'b1, s, c, o};
  endfunction

  function automatic void model_clear();
    m_total = 0;
    m_beats = 0;
  endfunction

  // Presents one beat starting at a falling edge; returns at the falling edge
  // after the accepting rising edge.
  task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic last);
    int t = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL beat_accept_timeout in_ready=%0b required=1", in_ready);
    end
    @(negedge clk);
    m_total += longint'(a) + longint'(b);
    m_beats++;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if (observed() !== '0) begin
      n_bad++; $display("FAIL reset_outputs observed=%h required=%h", observed(), {RW{1'b0}});
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready observed=%0b required=1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_clear();
  endtask

  task automatic test_single_beat();
    logic [RW-1:0] exp_r;
    send_beat(16'd3, 16'd4, 1'b1);
    exp_r = {1'b1, 24'd7, 16'd1, 1'b0};
    n_cmp++;
    if (observed() !== exp_r) begin
      n_bad++; $display("FAIL single_beat observed=%h required=%h", observed(), exp_r);
    end
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL single_done_in_ready observed=%0b required=0", in_ready);
    end
    model_clear();
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_bad++; $display("FAIL single_release observed=%b required=01", {out_valid, in_ready});
    end
  endtask

  task automatic test_three_beat();
    logic [W-1:0] av [3] = '{16'd1, 16'd3, 16'd5};
    logic [W-1:0] bv [3] = '{16'd2, 16'd4, 16'd6};
    logic [RW-1:0] exp_r;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_bad++; $display("FAIL three_beat_ready_%0d observed=%0b required=1", i, in_ready);
      end
      send_beat(av[i], bv[i], i == 2);
    end
    exp_r = {1'b1, 24'd21, 16'd3, 1'b0};
    n_cmp++;
    if ({observed(), in_ready} !== {exp_r, 1'b0}) begin
      n_bad++; $display("FAIL three_beat observed=%h required=%h", {observed(), in_ready}, {exp_r, 1'b0});
    end
    model_clear();
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_bad++; $display("FAIL three_beat_release observed=%b required=01", {out_valid, in_ready});
    end
  endtask

  task automatic test_overflow();
    logic [RW-1:0] exp_r;
    for (int i = 0; i < 257; i++) send_beat(16'hFFFF, 16'hFFFF, i == 256);
    exp_r = {1'b1, 24'd130558, 16'd257, 1'b1};
    n_cmp++;
    if (observed() !== exp_r) begin
      n_bad++; $display("FAIL overflow_fixed observed=%h required=%h", observed(), exp_r);
    end
    n_cmp++;
    if (observed() !== model_result()) begin
      n_bad++; $display("FAIL overflow_model observed=%h required=%h", observed(), model_result());
    end
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [RW-1:0] exp_r;
    int n;
    out_ready = 1'b0;
    n = $urandom_range(1, 4);
    for (int i = 0; i < n; i++) send_beat(W'($urandom), W'($urandom), i == n - 1);
    exp_r = model_result();
    model_clear();
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom);
      n_cmp++;
      if ({observed(), in_ready} !== {exp_r, 1'b0}) begin
        n_bad++; $display("FAIL backpressure_hold_%0d observed=%h required=%h", k, {observed(), in_ready}, {exp_r, 1'b0});
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_bad++; $display("FAIL backpressure_release observed=%b required=01", {out_valid, in_ready});
    end
    send_beat(16'd1, 16'd1, 1'b1);
    exp_r = {1'b1, 24'd2, 16'd1, 1'b0};
    n_cmp++;
    if (observed() !== exp_r) begin
      n_bad++; $display("FAIL backpressure_fresh observed=%h required=%h", observed(), exp_r);
    end
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_abort();
    logic [RW-1:0] exp_r;
    send_beat(16'd10, 16'd10, 1'b0);
    send_beat(16'd10, 16'd10, 1'b0);
    clr = 1'b1; in_valid = 1'b1; in_a = 16'd7; in_b = 16'd7; in_last = 1'b0;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    model_clear();
    send_beat(16'd1, 16'd1, 1'b1);
    exp_r = {1'b1, 24'd2, 16'd1, 1'b0};
    n_cmp++;
    if (observed() !== exp_r) begin
      n_bad++; $display("FAIL abort_discard observed=%h required=%h", observed(), exp_r);
    end
    model_clear();
    @(negedge clk);
    out_ready = 1'b0;
    send_beat(16'd2, 16'd2, 1'b1);
    model_clear();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_bad++; $display("FAIL abort_done observed=%b required=01", {out_valid, in_ready});
    end
    out_ready = 1'b1;
  endtask

  task automatic test_async_reset();
    logic [RW-1:0] exp_r;
    send_beat(16'd100, 16'd200, 1'b0);
    send_beat(16'd300, 16'd400, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({observed(), in_ready} !== {{RW{1'b0}}, 1'b1}) begin
      n_bad++; $display("FAIL async_mid_frame observed=%h required=%h", {observed(), in_ready}, {{RW{1'b0}}, 1'b1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    out_ready = 1'b0;
    send_beat(16'd9, 16'd9, 1'b1);
    model_clear();
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (observed() !== '0) begin
      n_bad++; $display("FAIL async_mid_done observed=%h required=%h", observed(), {RW{1'b0}});
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    send_beat(16'd5, 16'd6, 1'b1);
    exp_r = {1'b1, 24'd11, 16'd1, 1'b0};
    n_cmp++;
    if (observed() !== exp_r) begin
      n_bad++; $display("FAIL async_fresh_frame observed=%h required=%h", observed(), exp_r);
    end
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_random_frames();
    logic [RW-1:0] exp_r;
    int n, stall;
    for (int f = 0; f < 20; f++) begin
      n = $urandom_range(1, 12);
      out_ready = 1'b0;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        send_beat(W'($urandom), W'($urandom), i == n - 1);
      end
      exp_r = model_result();
      model_clear();
      stall = $urandom_range(0, 3);
      for (int k = 0; k <= stall; k++) begin
        n_cmp++;
        if (observed() !== exp_r) begin
          n_bad++; $display("FAIL random_frame_%0d_%0d observed=%h required=%h", f, k, observed(), exp_r);
        end
        if (k == stall) out_ready = 1'b1;
        @(negedge clk);
      end
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++; $display("FAIL random_frame_%0d_release out_valid=%0b required=0", f, out_valid);
      end
    end
    out_ready = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    test_reset();
    test_single_beat();
    test_three_beat();
    test_overflow();
    test_backpressure();
    test_abort();
    test_async_reset();
    test_random_frames();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
